issue_sched: RTL and testbench
==============================

Name: issue_sched

Overview:
- Single-issue in-order scheduler between the decode stage register and the four execution pipes: integer/branch, load-store, muldiv and trap/CSR.
- Tracks outstanding register writers in a 32-entry scoreboard and stalls on RAW and WAW hazards.
- Steers each decoded instruction to its pipe with valid/ready handshakes.
- Serialises trap and fence instructions by draining all in-flight work first.

Parameters:
- OUT_W, 3, width of the in-flight instruction counter; at most 2^OUT_W-1 instructions outstanding.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  instruction accepted this cycle
- dec_op_type  in  3  `OT_* class from decoder
- dec_operand1  in  2  `D_OPR1_* select
- dec_operand2  in  2  `D_OPR2_* select
- dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
- dec_wb_en  in  1  instruction writes rd
- dec_fencei  in  1  fence is fence.i
- ip_valid/ip_ready  out/in  1/1  integer pipe handshake; used for OT_INT and OT_BRANCH
- ls_valid/ls_ready  out/in  1/1  load-store pipe handshake; used for OT_LOAD and OT_STORE
- md_valid/md_ready  out/in  1/1  muldiv handshake; used for OT_MULDIV
- trap_valid/trap_ready  out/in  1/1  trap/CSR pipe handshake; used for OT_TRAP
- ip_done, ls_done, md_done  in  1 each  one-cycle completion pulse per retired instruction
- ip_wb_rd, ls_wb_rd, md_wb_rd  in  5 each  rd of the completing instruction; 0 if no writeback
- trap_done  in  1  trap pipe finished; redirect is already taken
- flush  in  1  pipeline kill from branch mispredict or trap
- fencei_req  out  1  one-cycle pulse to invalidate the I-cache
- busy  out  1  state != RUN or in-flight count != 0

Behaviour:
- Reset (async, rst_n low):
  - scoreboard all 0, in-flight count 0, state RUN, fencei_req 0.
  - All *_valid and dec_ready are forced 0 while rst_n is low.
- Operand usage:
  - rs1 is used iff dec_operand1 == `D_OPR1_RS1.
  - rs2 is used iff dec_operand2 == `D_OPR2_RS2.
  - x0 is never busy and is never set in the scoreboard.
- Effective busy(r) = sb[r] & ~(any *_done with *_wb_rd == r this cycle). Same-cycle writeback counts as free.
- hazard = (rs1 used & busy(rs1)) | (rs2 used & busy(rs2)) | (dec_wb_en & rd != 0 & busy(rd)).
- RUN state, non-serial op types:
  - Target pipe valid = dec_valid & ~hazard & ~cnt_full & ~flush.
  - dec_ready = that valid & the target pipe's ready. Combinational, zero-latency issue.
  - On accept: cnt += 1; if dec_wb_en & rd != 0, sb[rd] <= 1.
  - Only one *_valid is high per cycle.
- Completion: each *_done pulse does cnt -= 1 and clears sb[*_wb_rd] (if nonzero).
  - Up to three done pulses per cycle; the net count update is cnt + issue - popcount(dones).
  - When issue sets reg X and a done clears X in the same cycle, set wins.
- cnt_full = (cnt == 2^OUT_W-1); issue stalls while full.
- Serial ops (OT_TRAP, OT_FENCE) with dec_valid in RUN:
  - If cnt != 0 (after this cycle's dones), go to DRAIN; dec_ready = 0.
  - If cnt == 0: OT_FENCE retires immediately (dec_ready = 1; fencei_req = dec_fencei next cycle; stays RUN).
  - If cnt == 0: OT_TRAP asserts trap_valid; on trap_ready go to WAIT_TRAP.
- DRAIN: dec_ready = 0 until cnt reaches 0, then return to RUN to issue the serial op. This costs one extra cycle.
- WAIT_TRAP: dec_ready = 0 and all valids 0 until trap_done, then RUN. trap_done does not change cnt.
- flush (any state):
  - Next cycle: sb cleared, cnt 0, state RUN.
  - *_valid and dec_ready are 0 during the flush cycle; done pulses in that cycle are ignored.
  - A flush coincident with trap_done takes the same flush result.
- Illegal/page-fault instructions arrive as OT_TRAP and need no special handling.

Test Plan:
- Back-to-back independent ADDs to x1, x2, all ready=1 -> ip_valid and dec_ready high 2 consecutive cycles; sb bits 1,2 set, cnt=2; both ip_done with rd 1,2 -> cnt=0, sb=0.
- LD x5 issued, then ADD x6,x5,x3 -> dec_ready=0 until ls_done with ls_wb_rd=5; ADD issues in the same cycle as ls_done.
- MUL x7 in flight, then ADDI x7 (WAW) -> stalls until md_done/md_wb_rd=7; sb[7] remains 1 after the ADDI issues.
- Issue 7 stores with ls_done held low (OUT_W=3) -> 8th instruction stalls with cnt=7; one ls_done -> issues the next cycle.
- ECALL with cnt=2 -> DRAIN, dec_ready=0; after 2 dones, trap_valid=1; WAIT_TRAP until trap_done; busy=1 throughout.
- fence.i with cnt=0 -> accepted in 1 cycle, fencei_req pulses once the following cycle; flush mid-DRAIN -> next cycle state RUN, cnt=0, sb=0.

Source files
------------

// File: rtl/issue_sched.sv
// issue_sched: single-issue in-order scheduler between decode and the four
// execution pipes. A 32-entry scoreboard blocks RAW/WAW hazards, an in-flight
// counter bounds outstanding work, and trap/fence ops are serialised by draining.
module issue_sched #(
    parameter int OUT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [2:0]  dec_op_type,
    input  logic [1:0]  dec_operand1,
    input  logic [1:0]  dec_operand2,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_wb_en,
    input  logic        dec_fencei,
    output logic        ip_valid,
    input  logic        ip_ready,
    output logic        ls_valid,
    input  logic        ls_ready,
    output logic        md_valid,
    input  logic        md_ready,
    output logic        trap_valid,
    input  logic        trap_ready,
    input  logic        ip_done,
    input  logic        ls_done,
    input  logic        md_done,
    input  logic [4:0]  ip_wb_rd,
    input  logic [4:0]  ls_wb_rd,
    input  logic [4:0]  md_wb_rd,
    input  logic        trap_done,
    input  logic        flush,
    output logic        fencei_req,
    output logic        busy
);

    // Decoder operation classes and operand selects
    localparam logic [2:0] OT_INT     = 3'd0;
    localparam logic [2:0] OT_BRANCH  = 3'd1;
    localparam logic [2:0] OT_LOAD    = 3'd2;
    localparam logic [2:0] OT_STORE   = 3'd3;
    localparam logic [2:0] OT_MULDIV  = 3'd4;
    localparam logic [2:0] OT_TRAP    = 3'd5;
    localparam logic [2:0] OT_FENCE   = 3'd6;
    localparam logic [1:0] D_OPR1_RS1 = 2'd0;
    localparam logic [1:0] D_OPR2_RS2 = 2'd0;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_DRAIN     = 2'd1;
    localparam logic [1:0] ST_WAIT_TRAP = 2'd2;

    localparam logic [OUT_W-1:0] CNT_MAX = {OUT_W{1'b1}};

    // One-hot register mask; x0 never appears in the scoreboard.
    function automatic logic [31:0] reg_onehot(input logic en, input logic [4:0] r);
        logic [31:0] v;
        v = 32'd0;
        if (en && (r != 5'd0)) begin
            v[r] = 1'b1;
        end else begin
            v = 32'd0;
        end
        return v;
    endfunction

    logic [31:0]      sb_r;
    logic [OUT_W-1:0] cnt_r;
    logic [1:0]       state_r;
    logic             fencei_req_r;

    logic [31:0]      clr_s;
    logic [31:0]      set_s;
    logic [31:0]      sb_avail_s;
    logic [OUT_W-1:0] done_cnt_s;
    logic [OUT_W-1:0] cnt_eff_s;
    logic             cnt_full_s;
    logic             hazard_s;
    logic             is_serial_s;
    logic             tgt_ip_s, tgt_ls_s, tgt_md_s;
    logic             pipe_ready_s;
    logic             ip_v_s, ls_v_s, md_v_s, trap_v_s;
    logic             ready_s, issue_s, fence_acc_s;
    logic [1:0]       state_nx_s;

    // Same-cycle writebacks free their register for hazard checking.
    assign clr_s      = reg_onehot(ip_done, ip_wb_rd) | reg_onehot(ls_done, ls_wb_rd)
                      | reg_onehot(md_done, md_wb_rd);
    assign sb_avail_s = sb_r & ~clr_s;
    assign done_cnt_s = OUT_W'(ip_done) + OUT_W'(ls_done) + OUT_W'(md_done);
    assign cnt_eff_s  = cnt_r - done_cnt_s;
    assign cnt_full_s = (cnt_r == CNT_MAX);
    assign hazard_s   = ((dec_operand1 == D_OPR1_RS1) & sb_avail_s[dec_rs1])
                      | ((dec_operand2 == D_OPR2_RS2) & sb_avail_s[dec_rs2])
                      | (dec_wb_en & (dec_rd != 5'd0) & sb_avail_s[dec_rd]);
    assign is_serial_s = (dec_op_type == OT_TRAP) || (dec_op_type == OT_FENCE);
    assign set_s       = issue_s ? reg_onehot(dec_wb_en, dec_rd) : 32'd0;

    // Steer the decoded op class to its execution pipe.
    always_comb begin
        tgt_ip_s = 1'b0;
        tgt_ls_s = 1'b0;
        tgt_md_s = 1'b0;
        case (dec_op_type)
            OT_INT, OT_BRANCH: tgt_ip_s = 1'b1;
            OT_LOAD, OT_STORE: tgt_ls_s = 1'b1;
            OT_MULDIV:         tgt_md_s = 1'b1;
            default:           tgt_ip_s = !is_serial_s;
        endcase
        pipe_ready_s = (tgt_ip_s & ip_ready) | (tgt_ls_s & ls_ready) | (tgt_md_s & md_ready);
    end

    // Issue decision, handshakes and next state.
    always_comb begin
        ip_v_s      = 1'b0;
        ls_v_s      = 1'b0;
        md_v_s      = 1'b0;
        trap_v_s    = 1'b0;
        ready_s     = 1'b0;
        issue_s     = 1'b0;
        fence_acc_s = 1'b0;
        state_nx_s  = state_r;
        case (state_r)
            ST_RUN: begin
                if (dec_valid && !flush) begin
                    if (is_serial_s) begin
                        if (cnt_eff_s != {OUT_W{1'b0}}) begin
                            state_nx_s = ST_DRAIN;
                        end else if (dec_op_type == OT_FENCE) begin
                            ready_s     = 1'b1;
                            fence_acc_s = 1'b1;
                        end else begin
                            trap_v_s = 1'b1;
                            ready_s  = trap_ready;
                            state_nx_s = trap_ready ? ST_WAIT_TRAP : ST_RUN;
                        end
                    end else if (!hazard_s && !cnt_full_s) begin
                        ip_v_s  = tgt_ip_s;
                        ls_v_s  = tgt_ls_s;
                        md_v_s  = tgt_md_s;
                        ready_s = pipe_ready_s;
                        issue_s = pipe_ready_s;
                    end else begin
                        ready_s = 1'b0;
                    end
                end else begin
                    ready_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (cnt_eff_s == {OUT_W{1'b0}}) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_WAIT_TRAP: begin
                if (trap_done) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_WAIT_TRAP;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Scoreboard, in-flight counter, state and fence.i pulse; flush wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_r         <= 32'd0;
            cnt_r        <= {OUT_W{1'b0}};
            state_r      <= ST_RUN;
            fencei_req_r <= 1'b0;
        end else if (flush) begin
            sb_r         <= 32'd0;
            cnt_r        <= {OUT_W{1'b0}};
            state_r      <= ST_RUN;
            fencei_req_r <= 1'b0;
        end else begin
            sb_r         <= ((sb_r & ~clr_s) | set_s) & ~32'd1;
            cnt_r        <= cnt_r + OUT_W'(issue_s) - done_cnt_s;
            state_r      <= state_nx_s;
            fencei_req_r <= fence_acc_s & dec_fencei;
        end
    end

    assign ip_valid   = rst_n & ip_v_s;
    assign ls_valid   = rst_n & ls_v_s;
    assign md_valid   = rst_n & md_v_s;
    assign trap_valid = rst_n & trap_v_s;
    assign dec_ready  = rst_n & ready_s;
    assign fencei_req = fencei_req_r;
    assign busy       = (state_r != ST_RUN) || (cnt_r != {OUT_W{1'b0}});

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed-vector bench for issue_sched with hand-computed
// expectations for hazards, counter limits, serialisation and flush.
module tb_issue_sched;

    localparam logic [2:0] OT_INT    = 3'd0;
    localparam logic [2:0] OT_LOAD   = 3'd2;
    localparam logic [2:0] OT_STORE  = 3'd3;
    localparam logic [2:0] OT_MULDIV = 3'd4;
    localparam logic [2:0] OT_TRAP   = 3'd5;
    localparam logic [2:0] OT_FENCE  = 3'd6;
    localparam logic [1:0] SEL_REG   = 2'd0;
    localparam logic [1:0] SEL_IMM   = 2'd1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_ready;
    logic [2:0] dec_op_type;
    logic [1:0] dec_operand1, dec_operand2;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_wb_en, dec_fencei;
    logic       ip_valid, ip_ready, ls_valid, ls_ready, md_valid, md_ready;
    logic       trap_valid, trap_ready;
    logic       ip_done, ls_done, md_done;
    logic [4:0] ip_wb_rd, ls_wb_rd, md_wb_rd;
    logic       trap_done, flush, fencei_req, busy;

    int n_checks = 0;
    int n_errors = 0;

    issue_sched #(.OUT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op_type(dec_op_type),
        .dec_operand1(dec_operand1), .dec_operand2(dec_operand2),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_wb_en(dec_wb_en), .dec_fencei(dec_fencei),
        .ip_valid(ip_valid), .ip_ready(ip_ready),
        .ls_valid(ls_valid), .ls_ready(ls_ready),
        .md_valid(md_valid), .md_ready(md_ready),
        .trap_valid(trap_valid), .trap_ready(trap_ready),
        .ip_done(ip_done), .ls_done(ls_done), .md_done(md_done),
        .ip_wb_rd(ip_wb_rd), .ls_wb_rd(ls_wb_rd), .md_wb_rd(md_wb_rd),
        .trap_done(trap_done), .flush(flush),
        .fencei_req(fencei_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_op_type = OT_INT; dec_operand1 = SEL_IMM; dec_operand2 = SEL_IMM;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_wb_en = 1'b0; dec_fencei = 1'b0;
        ip_done = 1'b0; ls_done = 1'b0; md_done = 1'b0;
        ip_wb_rd = 5'd0; ls_wb_rd = 5'd0; md_wb_rd = 5'd0;
        trap_done = 1'b0; flush = 1'b0;
    endtask

    task automatic dec(input logic [2:0] op, input logic [1:0] o1, input logic [1:0] o2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wb, input logic fi);
        dec_valid = 1'b1; dec_op_type = op; dec_operand1 = o1; dec_operand2 = o2;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wb_en = wb; dec_fencei = fi;
    endtask

    initial begin
        idle();
        ip_ready = 1'b1; ls_ready = 1'b1; md_ready = 1'b1; trap_ready = 1'b1;
        rst_n = 1'b0;
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd1, 1'b1, 1'b0);
        #3;
        check("rst_dec_ready", dec_ready, 1'b0);
        check("rst_ip_valid", ip_valid, 1'b0);
        cyc();
        idle();
        rst_n = 1'b1;
        cyc();
        check("rst_cnt", dut.cnt_r, 3'd0);
        check("rst_sb", dut.sb_r, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_fencei", fencei_req, 1'b0);

        // Back-to-back independent ADDs to x1, x2
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd1, 1'b1, 1'b0); #1;
        check("add1_ip_valid", ip_valid, 1'b1);
        check("add1_dec_ready", dec_ready, 1'b1);
        check("add1_ls_valid", ls_valid, 1'b0);
        cyc();
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd2, 1'b1, 1'b0); #1;
        check("add2_ip_valid", ip_valid, 1'b1);
        check("add2_dec_ready", dec_ready, 1'b1);
        cyc();
        check("add_cnt", dut.cnt_r, 3'd2);
        check("add_sb", dut.sb_r, 32'h6);
        check("add_busy", busy, 1'b1);
        idle(); ip_done = 1'b1; ip_wb_rd = 5'd1; cyc();
        ip_wb_rd = 5'd2; cyc();
        idle();
        check("add_done_cnt", dut.cnt_r, 3'd0);
        check("add_done_sb", dut.sb_r, 32'd0);

        // RAW: LD x5 then ADD x6,x5,x3
        dec(OT_LOAD, SEL_REG, SEL_IMM, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0); #1;
        check("ld_ls_valid", ls_valid, 1'b1);
        cyc();
        dec(OT_INT, SEL_REG, SEL_REG, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0); #1;
        check("raw_stall_ready", dec_ready, 1'b0);
        check("raw_stall_ipv", ip_valid, 1'b0);
        cyc();
        check("raw_stall2_ready", dec_ready, 1'b0);
        ls_done = 1'b1; ls_wb_rd = 5'd5; #1;
        check("raw_wb_ready", dec_ready, 1'b1);
        check("raw_wb_ipv", ip_valid, 1'b1);
        cyc();
        check("raw_cnt", dut.cnt_r, 3'd1);
        check("raw_sb", dut.sb_r, 32'h40);
        idle(); ip_done = 1'b1; ip_wb_rd = 5'd6; cyc();
        idle();
        check("raw_end_cnt", dut.cnt_r, 3'd0);

        // WAW: MUL x7 then ADDI x7
        dec(OT_MULDIV, SEL_REG, SEL_REG, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0); #1;
        check("mul_md_valid", md_valid, 1'b1);
        cyc();
        dec(OT_INT, SEL_REG, SEL_IMM, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0); #1;
        check("waw_stall_ready", dec_ready, 1'b0);
        cyc();
        md_done = 1'b1; md_wb_rd = 5'd7; #1;
        check("waw_wb_ready", dec_ready, 1'b1);
        cyc();
        check("waw_sb_set_wins", dut.sb_r, 32'h80);
        check("waw_cnt", dut.cnt_r, 3'd1);
        idle(); ip_done = 1'b1; ip_wb_rd = 5'd7; cyc();
        idle();
        check("waw_end_sb", dut.sb_r, 32'd0);

        // Back-pressure then counter saturation with stores
        ls_ready = 1'b0;
        dec(OT_STORE, SEL_REG, SEL_REG, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); #1;
        check("bp_ls_valid", ls_valid, 1'b1);
        check("bp_dec_ready", dec_ready, 1'b0);
        cyc();
        check("bp_cnt", dut.cnt_r, 3'd0);
        ls_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("st_ready", dec_ready, 1'b1);
            cyc();
        end
        check("st_cnt_full", dut.cnt_r, 3'd7);
        #1;
        check("st_full_ready", dec_ready, 1'b0);
        check("st_full_lsv", ls_valid, 1'b0);
        cyc();
        ls_done = 1'b1; #1;
        check("st_done_ready", dec_ready, 1'b0);
        cyc();
        check("st_cnt6", dut.cnt_r, 3'd6);
        ls_done = 1'b0; #1;
        check("st_next_ready", dec_ready, 1'b1);
        cyc();
        check("st_cnt7", dut.cnt_r, 3'd7);
        idle(); ls_done = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        idle();
        check("st_drain_cnt", dut.cnt_r, 3'd0);

        // ECALL with two ops in flight
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd1, 1'b1, 1'b0); cyc();
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd2, 1'b1, 1'b0); cyc();
        dec(OT_TRAP, SEL_IMM, SEL_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        check("ecall_ready0", dec_ready, 1'b0);
        check("ecall_trapv0", trap_valid, 1'b0);
        cyc();
        check("drain_busy", busy, 1'b1);
        ip_done = 1'b1; ip_wb_rd = 5'd1; #1;
        check("drain_ready", dec_ready, 1'b0);
        cyc();
        ip_wb_rd = 5'd2; #1;
        check("drain_trapv", trap_valid, 1'b0);
        cyc();
        check("drain_cnt", dut.cnt_r, 3'd0);
        ip_done = 1'b0; ip_wb_rd = 5'd0; #1;
        check("ecall_trapv", trap_valid, 1'b1);
        check("ecall_ready", dec_ready, 1'b1);
        cyc();
        check("wait_busy", busy, 1'b1);
        dec(OT_INT, SEL_REG, SEL_REG, 5'd3, 5'd4, 5'd1, 1'b1, 1'b0); #1;
        check("wait_ready", dec_ready, 1'b0);
        check("wait_ipv", ip_valid, 1'b0);
        cyc();
        idle(); trap_done = 1'b1; cyc();
        idle();
        check("trap_done_busy", busy, 1'b0);

        // fence.i with nothing in flight
        dec(OT_FENCE, SEL_IMM, SEL_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1;
        check("fence_ready", dec_ready, 1'b1);
        cyc();
        idle();
        check("fencei_pulse", fencei_req, 1'b1);
        cyc();
        check("fencei_low", fencei_req, 1'b0);

        // Flush in the middle of a drain
        dec(OT_INT, SEL_REG, SEL_REG, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); cyc();
        dec(OT_FENCE, SEL_IMM, SEL_IMM, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1;
        check("fdrain_ready", dec_ready, 1'b0);
        cyc();
        check("fdrain_busy", busy, 1'b1);
        flush = 1'b1; ip_done = 1'b1; ip_wb_rd = 5'd3; #1;
        check("flush_ready", dec_ready, 1'b0);
        cyc();
        flush = 1'b0; ip_done = 1'b0; ip_wb_rd = 5'd0;
        check("flush_cnt", dut.cnt_r, 3'd0);
        check("flush_sb", dut.sb_r, 32'd0);
        check("flush_busy", busy, 1'b0);
        #1;
        check("post_flush_fence", dec_ready, 1'b1);
        cyc();
        idle();
        check("post_flush_fencei", fencei_req, 1'b1);

        // Flush during RUN suppresses issue
        dec(OT_INT, SEL_REG, SEL_REG, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); flush = 1'b1; #1;
        check("flush_run_ipv", ip_valid, 1'b0);
        cyc();
        idle();
        check("flush_run_cnt", dut.cnt_r, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
